univ_shift_reg: RTL and testbench



---
 rtl/usr_pkg.sv | 15 +
 rtl/dff_cell.sv | 23 ++
 rtl/univ_shift_reg.sv | 61 ++++++
 tb/tb_univ_shift_reg.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared mode encodings for the universal shift register.
package usr_pkg;

  localparam int unsigned MODE_W = 3;

  localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
  localparam logic [MODE_W-1:0] MODE_SHL  = 3'b001;
  localparam logic [MODE_W-1:0] MODE_SHR  = 3'b010;
  localparam logic [MODE_W-1:0] MODE_ROL  = 3'b011;
  localparam logic [MODE_W-1:0] MODE_ROR  = 3'b100;
  localparam logic [MODE_W-1:0] MODE_LOAD = 3'b101;
  localparam logic [MODE_W-1:0] MODE_CLR  = 3'b110;
  localparam logic [MODE_W-1:0] MODE_SET  = 3'b111;

endpackage

// File: rtl/dff_cell.sv
// Single-bit rising-edge flop with synchronous active-high reset and a
// separately registered complement output.
module dff_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q,
  output logic qbar
);

  // qbar has its own flop so neither output passes through combinational logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= rst_val;
      qbar <= ~rst_val;
    end else begin
      q    <= d;
      qbar <= ~d;
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal register: hold, shift, rotate, load, clear and set,
// built from per-bit dff_cell flops.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              sin_l,
  input  logic              sin_r,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  qbar,
  output logic              sout_l,
  output logic              sout_r
);

  // Extended vectors keep shifts and rotates legal when WIDTH is 1.
  logic [WIDTH:0]   shl_ext, shr_ext, rol_ext, ror_ext;
  logic [WIDTH-1:0] nxt;

  always_comb begin
    shl_ext = {q, sin_l};
    shr_ext = {sin_r, q};
    rol_ext = {q, q[WIDTH-1]};
    ror_ext = {q[0], q};
    nxt     = q;
    if (en) begin
      unique case (mode)
        MODE_HOLD: nxt = q;
        MODE_SHL:  nxt = shl_ext[WIDTH-1:0];
        MODE_SHR:  nxt = shr_ext[WIDTH:1];
        MODE_ROL:  nxt = rol_ext[WIDTH-1:0];
        MODE_ROR:  nxt = ror_ext[WIDTH:1];
        MODE_LOAD: nxt = d;
        MODE_CLR:  nxt = '0;
        MODE_SET:  nxt = '1;
        default:   nxt = q;
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RESET_VAL[i]),
      .d       (nxt[i]),
      .q       (q[i]),
      .qbar    (qbar[i])
    );
  end

  assign sout_l = q[WIDTH-1];
  assign sout_r = q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed-vector bench for univ_shift_reg at WIDTH=8 and WIDTH=1.
module tb_univ_shift_reg;
  import usr_pkg::*;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       rst, en, sin_l, sin_r;
  logic [2:0] mode;
  logic [7:0] d, q, qbar;
  logic       sout_l, sout_r;

  // WIDTH=1 instance
  logic       rst1, en1, sin_l1, sin_r1;
  logic [2:0] mode1;
  logic [0:0] d1, q1, qbar1;
  logic       sout_l1, sout_r1;

  int n_tests = 0;
  int n_fail  = 0;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut8 (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .q      (q),
    .qbar   (qbar),
    .sout_l (sout_l),
    .sout_r (sout_r)
  );

  univ_shift_reg #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
    .clk    (clk),
    .rst    (rst1),
    .en     (en1),
    .mode   (mode1),
    .d      (d1),
    .sin_l  (sin_l1),
    .sin_r  (sin_r1),
    .q      (q1),
    .qbar   (qbar1),
    .sout_l (sout_l1),
    .sout_r (sout_r1)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic op8(input logic [2:0] m, input logic [7:0] dv, input logic sl, input logic sr);
    en = 1'b1; mode = m; d = dv; sin_l = sl; sin_r = sr;
    step();
  endtask

  task automatic op1(input logic [2:0] m, input logic sl, input logic sr);
    en1 = 1'b1; mode1 = m; sin_l1 = sl; sin_r1 = sr;
    step();
  endtask

  logic [7:0] pat;

  initial begin
    rst = 1'b1; en = 1'b1; mode = MODE_LOAD; d = 8'hFF; sin_l = 1'b0; sin_r = 1'b0;
    rst1 = 1'b1; en1 = 1'b0; mode1 = MODE_HOLD; d1 = 1'b0; sin_l1 = 1'b0; sin_r1 = 1'b0;
    #2;
    step();
    check_eq("reset_q", 64'(q), 64'h A5);
    check_eq("reset_qbar", 64'(qbar), 64'h5A);
    check_eq("w1_reset_q", 64'(q1), 64'h0);
    check_eq("w1_reset_qbar", 64'(qbar1), 64'h1);

    // Reset keeps priority while mode/en wander.
    mode = MODE_SET; en = 1'b0;
    step();
    check_eq("reset_prio_q", 64'(q), 64'hA5);
    rst = 1'b0; rst1 = 1'b0;

    op8(MODE_LOAD, 8'h3C, 1'b0, 1'b0);
    check_eq("load_3c", 64'(q), 64'h3C);
    en = 1'b0; mode = MODE_SHL; sin_l = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("hold_en0_q", 64'(q), 64'h3C);
      check_eq("hold_en0_qbar", 64'(qbar), 64'hC3);
    end
    check_eq("hold_sout_l", 64'(sout_l), 64'h0);
    check_eq("hold_sout_r", 64'(sout_r), 64'h0);

    op8(MODE_LOAD, 8'h81, 1'b0, 1'b0);
    op8(MODE_SHL, 8'h00, 1'b1, 1'b0);
    check_eq("shl_81", 64'(q), 64'h03);

    op8(MODE_LOAD, 8'h81, 1'b0, 1'b0);
    check_eq("sout_r_81", 64'(sout_r), 64'h1);
    check_eq("sout_l_81", 64'(sout_l), 64'h1);
    op8(MODE_SHR, 8'h00, 1'b0, 1'b0);
    check_eq("shr_81", 64'(q), 64'h40);

    op8(MODE_LOAD, 8'h81, 1'b0, 1'b0);
    op8(MODE_ROL, 8'h00, 1'b0, 1'b0);
    check_eq("rol_81", 64'(q), 64'h03);

    op8(MODE_LOAD, 8'h96, 1'b0, 1'b0);
    op8(MODE_ROL, 8'h00, 1'b0, 1'b0);
    check_eq("rol1_96", 64'(q), 64'h2D);
    for (int i = 1; i < 8; i++) op8(MODE_ROL, 8'h00, 1'b0, 1'b0);
    check_eq("rol8_96", 64'(q), 64'h96);

    op8(MODE_LOAD, 8'h01, 1'b0, 1'b0);
    op8(MODE_ROR, 8'h00, 1'b0, 1'b0);
    check_eq("ror_01", 64'(q), 64'h80);

    // Serial-in: first bit driven ends up in bit 0.
    op8(MODE_LOAD, 8'h00, 1'b0, 1'b0);
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) op8(MODE_SHR, 8'h00, 1'b0, pat[i]);
    check_eq("serial_in_4d", 64'(q), 64'h4D);

    for (int i = 0; i < 3; i++) op8(MODE_SHR, 8'h00, 1'b0, 1'b1);
    check_eq("serial2_pre_rst", 64'(q), 64'hE9);
    rst = 1'b1;
    op8(MODE_SHR, 8'h00, 1'b0, 1'b1);
    rst = 1'b0;
    check_eq("serial2_rst", 64'(q), 64'hA5);
    op8(MODE_SHR, 8'h00, 1'b0, 1'b1);
    check_eq("resume_shr", 64'(q), 64'hD2);
    op8(MODE_SHL, 8'h00, 1'b0, 1'b0);
    check_eq("resume_shl", 64'(q), 64'hA4);

    op8(MODE_CLR, 8'h55, 1'b1, 1'b1);
    check_eq("clr_q", 64'(q), 64'h00);
    check_eq("clr_qbar", 64'(qbar), 64'hFF);
    op8(MODE_SET, 8'h00, 1'b0, 1'b0);
    check_eq("set_q", 64'(q), 64'hFF);
    check_eq("set_qbar", 64'(qbar), 64'h00);
    op8(MODE_HOLD, 8'h12, 1'b0, 1'b0);
    check_eq("hold_mode", 64'(q), 64'hFF);
    en = 1'b0;

    // WIDTH=1 corner cases.
    op1(MODE_SHL, 1'b1, 1'b0);
    check_eq("w1_shl_q", 64'(q1), 64'h1);
    check_eq("w1_shl_qbar", 64'(qbar1), 64'h0);
    check_eq("w1_sout_l", 64'(sout_l1), 64'h1);
    check_eq("w1_sout_r", 64'(sout_r1), 64'h1);
    op1(MODE_ROL, 1'b0, 1'b0);
    check_eq("w1_rol", 64'(q1), 64'h1);
    op1(MODE_ROR, 1'b0, 1'b0);
    check_eq("w1_ror", 64'(q1), 64'h1);
    op1(MODE_CLR, 1'b1, 1'b1);
    check_eq("w1_clr", 64'(q1), 64'h0);
    op1(MODE_SHR, 1'b0, 1'b1);
    check_eq("w1_shr", 64'(q1), 64'h1);
    op1(MODE_SHL, 1'b0, 1'b1);
    check_eq("w1_shl0", 64'(q1), 64'h0);
    op1(MODE_SET, 1'b0, 1'b0);
    check_eq("w1_set_q", 64'(q1), 64'h1);
    check_eq("w1_set_qbar", 64'(qbar1), 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
